// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word at a time and shifts it out as a UART 8N1 frame.
// All outputs are registered; txd only moves on bit boundaries.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int RD_LATENCY   = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  txEn,
    input  logic                  fifoEmpty,
    input  logic [DATA_WIDTH-1:0] fifoData,
    output logic                  rdEn,
    output logic                  txd,
    output logic                  busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam int WW = $clog2(RD_LATENCY + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(RD_LATENCY - 1);
    localparam logic          STOP_LAST = (STOP_BITS > 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                r_state;
    logic [BW-1:0]         r_baud;
    logic [IW-1:0]         r_bit;
    logic [WW-1:0]         r_wait;
    logic                  r_stop;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_txd;
    logic                  r_rdEn;
    logic                  r_busy;

    state_t                w_state;
    logic [BW-1:0]         w_baud;
    logic [IW-1:0]         w_bit;
    logic [WW-1:0]         w_wait;
    logic                  w_stop;
    logic [DATA_WIDTH-1:0] w_shift;
    logic                  w_txd;
    logic                  w_rdEn;
    logic                  w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_wait  <= '0;
            r_stop  <= 1'b0;
            r_shift <= '0;
            r_txd   <= 1'b1;
            r_rdEn  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_baud  <= w_baud;
            r_bit   <= w_bit;
            r_wait  <= w_wait;
            r_stop  <= w_stop;
            r_shift <= w_shift;
            r_txd   <= w_txd;
            r_rdEn  <= w_rdEn;
            r_busy  <= w_busy;
        end
    end

    always_comb begin
        w_state = r_state;
        w_baud  = r_baud;
        w_bit   = r_bit;
        w_wait  = r_wait;
        w_stop  = r_stop;
        w_shift = r_shift;

        unique case (r_state)
            S_IDLE: begin
                if (txEn && !fifoEmpty) begin
                    w_state = S_POP;
                end
            end
            S_POP: begin
                w_state = S_WAIT;
                w_wait  = '0;
            end
            S_WAIT: begin
                if (r_wait == WAIT_LAST) begin
                    w_shift = fifoData;
                    w_baud  = '0;
                    w_state = S_START;
                end else begin
                    w_wait = r_wait + 1'b1;
                end
            end
            S_START: begin
                if (r_baud == BAUD_LAST) begin
                    w_baud  = '0;
                    w_bit   = '0;
                    w_state = S_DATA;
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end
            S_DATA: begin
                if (r_baud == BAUD_LAST) begin
                    w_baud  = '0;
                    w_shift = {1'b0, r_shift[DATA_WIDTH-1:1]};
                    if (r_bit == BIT_LAST) begin
                        w_stop  = 1'b0;
                        w_state = S_STOP;
                    end else begin
                        w_bit = r_bit + 1'b1;
                    end
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end
            S_STOP: begin
                if (r_baud == BAUD_LAST) begin
                    w_baud = '0;
                    if (r_stop == STOP_LAST) begin
                        w_state = S_IDLE;
                    end else begin
                        w_stop = 1'b1;
                    end
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register with it.
        w_rdEn = (w_state == S_POP);
        w_busy = (w_state != S_IDLE);
        w_txd  = 1'b1;
        if (w_state == S_START) begin
            w_txd = 1'b0;
        end else if (w_state == S_DATA) begin
            w_txd = w_shift[0];
        end
    end

    assign rdEn = r_rdEn;
    assign txd  = r_txd;
    assign busy = r_busy;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small FIFO model and frame sampler.
// CLKS_PER_BIT=4, RD_LATENCY=1, so a frame is 40 cycles and pops are 43 apart.
module tb_fifo_uart_tx;

    logic       clk;
    logic       rst;
    logic       txEn;
    logic       fifoEmpty;
    logic [7:0] fifoData;
    logic       rdEn;
    logic       txd;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] mem [32];
    int         push_cnt  = 0;
    int         pop_cnt   = 0;
    int         pop_at [32];
    int         cyc       = 0;
    int         viol      = 0;
    logic       prev_busy = 1'b0;
    logic       prev_rd   = 1'b0;
    logic       hold_full = 1'b0;

    fifo_uart_tx #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(4),
        .RD_LATENCY  (1),
        .STOP_BITS   (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .txEn     (txEn),
        .fifoEmpty(fifoEmpty),
        .fifoData (fifoData),
        .rdEn     (rdEn),
        .txd      (txd),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifoEmpty = !hold_full && (push_cnt == pop_cnt);

    // FIFO read port: data valid one cycle after rdEn.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rdEn) begin
            fifoData <= mem[pop_cnt % 32];
            pop_at[pop_cnt % 32] <= cyc;
            pop_cnt <= pop_cnt + 1;
            if (prev_busy || prev_rd) viol <= viol + 1;
        end
        prev_busy <= busy;
        prev_rd   <= rdEn;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[push_cnt % 32] = b;
        push_cnt = push_cnt + 1;
    endtask

    task automatic wait_pop(input string tag);
        int n;
        n = 0;
        while (rdEn !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_pop_seen"}, 32'(rdEn), 32'd1);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] exp);
        int         n;
        int         bad_shape;
        logic [39:0] s;
        logic [7:0] d;
        n = 0;
        bad_shape = 0;
        @(negedge clk);
        while (txd !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start_seen"}, 32'(txd), 32'd0);
        for (int i = 0; i < 40; i++) begin
            s[i] = txd;
            if (busy !== 1'b1) bad_shape++;
            if (i < 39) @(negedge clk);
        end
        for (int b = 0; b < 10; b++)
            for (int k = 1; k < 4; k++)
                if (s[4*b+k] !== s[4*b]) bad_shape++;
        for (int j = 0; j < 8; j++) d[j] = s[4*(j+1)];
        chk({tag, "_data"}, 32'(d), 32'(exp));
        chk({tag, "_shape"}, 32'(bad_shape), 32'd0);
        chk({tag, "_startstop"}, 32'({s[36], s[0]}), 32'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pc0;
        int err;
        rst  = 1'b1;
        txEn = 1'b1;
        push(8'hA5);

        // reset holds outputs idle even with data available
        repeat (3) begin
            @(negedge clk);
            chk("rst_outs", 32'({txd, rdEn, busy}), 32'b100);
        end
        rst = 1'b0;
        chk("rst_rd_drop", 32'(rdEn), 32'd0);
        @(negedge clk);
        chk("first_pop_hi", 32'(rdEn), 32'd1);
        chk("first_pop_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("first_pop_lo", 32'(rdEn), 32'd0);

        run_frame("t2_a5", 8'hA5);
        @(negedge clk);
        chk("t2_busy_fall", 32'(busy), 32'd0);
        chk("t2_idle_txd", 32'(txd), 32'd1);
        chk("t2_pops", 32'(pop_cnt), 32'd1);

        // back-to-back
        pc0 = pop_cnt;
        push(8'h00);
        push(8'hFF);
        run_frame("t3_00", 8'h00);
        run_frame("t3_ff", 8'hFF);
        repeat (10) @(negedge clk);
        chk("t3_pops", 32'(pop_cnt - pc0), 32'd2);
        chk("t3_spacing", 32'(pop_at[(pc0+1)%32] - pop_at[pc0%32]), 32'd43);
        chk("t3_viol", 32'(viol), 32'd0);

        // txEn gating
        txEn = 1'b0;
        pc0 = pop_cnt;
        push(8'h3C);
        push(8'h77);
        err = 0;
        repeat (100) begin
            @(negedge clk);
            if (rdEn !== 1'b0 || busy !== 1'b0) err++;
        end
        chk("t4_gated_rd", 32'(err), 32'd0);
        chk("t4_gated_pops", 32'(pop_cnt - pc0), 32'd0);
        txEn = 1'b1;
        fork
            run_frame("t4_3c", 8'h3C);
            begin
                repeat (15) @(negedge clk);
                txEn = 1'b0;
            end
        join
        repeat (60) @(negedge clk);
        chk("t4_after_drop", 32'(pop_cnt - pc0), 32'd1);
        chk("t4_idle_txd", 32'(txd), 32'd1);
        txEn = 1'b1;
        run_frame("t4_77", 8'h77);
        repeat (5) @(negedge clk);
        chk("t4_pops", 32'(pop_cnt - pc0), 32'd2);

        // reset mid-frame during data bit 3
        pc0 = pop_cnt;
        push(8'h81);
        push(8'h42);
        @(negedge clk);
        wait_pop("t5");
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_abort", 32'({txd, rdEn, busy}), 32'b100);
        rst = 1'b0;
        run_frame("t5_42", 8'h42);
        repeat (20) @(negedge clk);
        chk("t5_pops", 32'(pop_cnt - pc0), 32'd2);
        chk("t5_idle", 32'({txd, busy}), 32'b10);

        // fifoEmpty rises during the stop bit of the last word
        pc0 = pop_cnt;
        hold_full = 1'b1;
        push(8'h5A);
        fork
            run_frame("t6_5a", 8'h5A);
            begin
                @(negedge clk);
                wait_pop("t6");
                repeat (39) @(negedge clk);
                hold_full = 1'b0;
            end
        join
        err = 0;
        repeat (30) begin
            @(negedge clk);
            if (rdEn !== 1'b0 || txd !== 1'b1) err++;
        end
        chk("t6_quiet", 32'(err), 32'd0);
        chk("t6_pops", 32'(pop_cnt - pc0), 32'd1);
        chk("t6_viol", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
